regfile_2r1w_sb: RTL and testbench
==================================

Name: regfile_2r1w_sb

Overview:
- Parametrised general-purpose register file for the MIPS datapath: two registered read ports, one write port, optional same-cycle write-to-read bypass, optional hardwired-zero register 0.
- Carries a per-register pending-write scoreboard. Decode claims a destination; writeback clears it. The hazard unit reads busy flags for both source operands.
- Reads and writes are independent every cycle: a write never blocks a read.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read and suppresses its busy flag; 0 = no forwarding.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- rd_en  input  1  read enable; loads both read-data registers.
- ra_addr  input  ADDR_W  port A read address.
- rb_addr  input  ADDR_W  port B read address.
- ra_data  output  DATA_W  port A read data, registered.
- rb_data  output  DATA_W  port B read data, registered.
- claim_en  input  1  marks claim_addr as having a pending write.
- claim_addr  input  ADDR_W  destination being claimed.
- ra_busy  output  1  pending write on ra_addr, combinational.
- rb_busy  output  1  pending write on rb_addr, combinational.
- busy_any  output  1  OR of all busy bits, combinational.

Behaviour:
- Reset (rst=1 at a clock edge) takes priority over we, rd_en and claim_en:
  - All NUM_REGS registers are set to 0.
  - ra_data and rb_data are set to 0.
  - All busy bits are cleared, so ra_busy, rb_busy and busy_any read 0 after the edge.
  - Reset asserted mid-operation discards any write or claim presented in that cycle.
- Write: if we=1, register[waddr] takes wdata at the edge. With ZERO_REG=1 and waddr=0 the write is dropped.
- Read latency is 1 cycle. If rd_en=1 at edge N, ra_data and rb_data show the selected values after edge N. If rd_en=0, both outputs hold their previous value.
- Read data selection for each port (port A shown; port B is the same on rb_addr):
  - ZERO_REG=1 and ra_addr=0: 0, even if a write to 0 is presented.
  - Otherwise BYPASS=1, we=1 and ra_addr=waddr: wdata from the current cycle.
  - Otherwise: the stored register value from before the edge.
- With BYPASS=0, a read of an address being written in the same cycle returns the old value. The new value is visible on the next read.
- Both ports may read the same address; both outputs get the same value.
- Scoreboard: one busy bit per register. Next-state per address i, in priority order:
  - rst forces 0.
  - Otherwise, if claim_en=1 and claim_addr=i: set to 1.
  - Otherwise, if we=1 and waddr=i: clear to 0.
  - Otherwise hold.
- A simultaneous write and claim to the same address leaves busy=1: the older producer retires while the new one takes ownership.
- With ZERO_REG=1, claims of register 0 are ignored and busy[0] is constant 0.
- ra_busy = busy[ra_addr], masked to 0 when any of the following holds:
  - BYPASS=1, we=1 and waddr=ra_addr.
  - ZERO_REG=1 and ra_addr=0.
- rb_busy is the same on rb_addr. Busy outputs do not depend on rd_en.
- Claims are not counted: claiming an already-busy register keeps it at 1, and a single write clears it.
- busy_any is the OR of the stored busy bits only. It is not masked by a same-cycle write or by a same-cycle claim.
- Addresses are always in range (2**ADDR_W entries), so no out-of-range case exists.
- Inputs are don't-care when their enable is low.

Test Plan:
- Reset: load r3=0x11, claim r4; pulse rst, then rd_en with ra=3, rb=4 -> ra_data=0, rb_data=0, ra_busy=0, rb_busy=0, busy_any=0.
- Basic write/read: we, waddr=7, wdata=0xDEADBEEF; next cycle rd_en, ra=7 -> ra_data=0xDEADBEEF one cycle later; rb=0 -> rb_data=0.
- Bypass: with r9=0x1, present we, waddr=9, wdata=0x2 and rd_en, ra=9, rb=9 in the same cycle -> ra_data=rb_data=0x2. Repeat with BYPASS=0 -> both 0x1.
- Zero register: we, waddr=0, wdata=0xFFFFFFFF plus claim_en, claim_addr=0; then read ra=0 -> ra_data=0, ra_busy=0, busy_any=0. With ZERO_REG=0 -> ra_data=0xFFFFFFFF.
- Scoreboard: claim r5 -> ra_busy=1 for ra=5 the next cycle, busy_any=1. Then in one cycle we, waddr=5 plus claim r5 -> busy stays 1. A later write to r5 alone -> ra_busy=0, busy_any=0.
- rd_en hold: read r2=0x55; change r2 to 0x66 with rd_en=0 -> ra_data stays 0x55 until the next rd_en, then 0x66.

Source files
------------

// File: rtl/regfile_2r1w_sb_if.sv
// Register-file access bundle: write port, two read ports and the
// pending-write scoreboard claim/busy signals.
interface regfile_2r1w_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              claim_en;
  logic [ADDR_W-1:0] claim_addr;
  logic              ra_busy;
  logic              rb_busy;
  logic              busy_any;

  modport master (
    output we, waddr, wdata, rd_en, ra_addr, rb_addr, claim_en, claim_addr,
    input  ra_data, rb_data, ra_busy, rb_busy, busy_any
  );

  modport slave (
    input  we, waddr, wdata, rd_en, ra_addr, rb_addr, claim_en, claim_addr,
    output ra_data, rb_data, ra_busy, rb_busy, busy_any
  );
endinterface

// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with registered reads, optional write bypass,
// optional hardwired-zero r0 and a per-register pending-write scoreboard.
module regfile_2r1w_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic               clk,
  input logic               rst,
  regfile_2r1w_sb_if.slave  rf
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [DATA_W-1:0]   r_ra_data;
  logic [DATA_W-1:0]   r_rb_data;

  logic [DATA_W-1:0]   w_ra_val;
  logic [DATA_W-1:0]   w_rb_val;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_wr_ok;
  logic                w_ra_fwd;
  logic                w_rb_fwd;
  logic                w_ra_zero;
  logic                w_rb_zero;

  assign w_wr_ok   = rf.we && !((ZERO_REG != 0) && (rf.waddr == '0));
  assign w_ra_fwd  = (BYPASS != 0) && rf.we && (rf.waddr == rf.ra_addr);
  assign w_rb_fwd  = (BYPASS != 0) && rf.we && (rf.waddr == rf.rb_addr);
  assign w_ra_zero = (ZERO_REG != 0) && (rf.ra_addr == '0);
  assign w_rb_zero = (ZERO_REG != 0) && (rf.rb_addr == '0);

  always_comb begin
    w_ra_val = r_mem[rf.ra_addr];
    if (w_ra_fwd)  w_ra_val = rf.wdata;
    if (w_ra_zero) w_ra_val = '0;
    w_rb_val = r_mem[rf.rb_addr];
    if (w_rb_fwd)  w_rb_val = rf.wdata;
    if (w_rb_zero) w_rb_val = '0;
  end

  // Claim is applied after the write-clear so a same-cycle claim wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rf.we && (rf.waddr == ADDR_W'(i)))             w_busy_nxt[i] = 1'b0;
      if (rf.claim_en && (rf.claim_addr == ADDR_W'(i)))  w_busy_nxt[i] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[rf.waddr] <= rf.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_ra_data <= '0;
      r_rb_data <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (rf.rd_en) begin
        r_ra_data <= w_ra_val;
        r_rb_data <= w_rb_val;
      end
    end
  end

  assign rf.ra_data  = r_ra_data;
  assign rf.rb_data  = r_rb_data;
  assign rf.ra_busy  = r_busy[rf.ra_addr] && !w_ra_fwd && !w_ra_zero;
  assign rf.rb_busy  = r_busy[rf.rb_addr] && !w_rb_fwd && !w_rb_zero;
  assign rf.busy_any = |r_busy;
endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench: default instance (ZERO_REG=1, BYPASS=1) and an alternate
// instance (ZERO_REG=0, BYPASS=0) driven with identical stimulus.
module tb_regfile_2r1w_sb;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  regfile_2r1w_sb_if #(.DATA_W(32), .ADDR_W(5)) u_if ();
  regfile_2r1w_sb_if #(.DATA_W(32), .ADDR_W(5)) a_if ();

  regfile_2r1w_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .rf  (u_if.slave)
  );

  regfile_2r1w_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) a_dut (
    .clk (clk),
    .rst (rst),
    .rf  (a_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rd, input logic [4:0] ra, input logic [4:0] rb,
                       input logic ce, input logic [4:0] ca);
    u_if.we = we; u_if.waddr = wa; u_if.wdata = wd; u_if.rd_en = rd;
    u_if.ra_addr = ra; u_if.rb_addr = rb; u_if.claim_en = ce; u_if.claim_addr = ca;
    a_if.we = we; a_if.waddr = wa; a_if.wdata = wd; a_if.rd_en = rd;
    a_if.ra_addr = ra; a_if.rb_addr = rb; a_if.claim_en = ce; a_if.claim_addr = ca;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0);
    tick();
    chk("por_ra_data", u_if.ra_data, 32'h0);
    chk("por_busy_any", {31'b0, u_if.busy_any}, 32'h0);

    // Reset clears data and busy bits
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd3, 5'd4, 1'b1, 5'd4);
    tick();
    idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd4, 1'b0, 5'd0);
    chk("pre_rst_rb_busy", {31'b0, u_if.rb_busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0);
    chk("rst_ra_busy", {31'b0, u_if.ra_busy}, 32'h0);
    chk("rst_rb_busy", {31'b0, u_if.rb_busy}, 32'h0);
    chk("rst_busy_any", {31'b0, u_if.busy_any}, 32'h0);
    tick();
    chk("rst_ra_data", u_if.ra_data, 32'h0);
    chk("rst_rb_data", u_if.rb_data, 32'h0);

    // Basic write then read
    drive(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0);
    tick();
    chk("wr_ra_data", u_if.ra_data, 32'hDEADBEEF);
    chk("wr_rb_data", u_if.rb_data, 32'h0);
    chk("wr_alt_ra_data", a_if.ra_data, 32'hDEADBEEF);

    // Same-cycle write/read: bypass vs. no bypass
    drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0);
    tick();
    chk("byp_ra_data", u_if.ra_data, 32'h2);
    chk("byp_rb_data", u_if.rb_data, 32'h2);
    chk("nobyp_ra_data", a_if.ra_data, 32'h1);
    chk("nobyp_rb_data", a_if.rb_data, 32'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0);
    tick();
    chk("nobyp_next_ra", a_if.ra_data, 32'h2);

    // Register 0: hardwired vs. ordinary
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
    chk("zr_ra_busy", {31'b0, u_if.ra_busy}, 32'h0);
    chk("zr_busy_any", {31'b0, u_if.busy_any}, 32'h0);
    chk("alt_r0_ra_busy", {31'b0, a_if.ra_busy}, 32'h1);
    tick();
    chk("zr_ra_data", u_if.ra_data, 32'h0);
    chk("alt_r0_ra_data", a_if.ra_data, 32'hFFFFFFFF);
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    chk("zr_byp_ra_data", u_if.ra_data, 32'h0);
    chk("alt_r0_cleared", {31'b0, a_if.busy_any}, 32'h0);

    // Scoreboard claim / write interaction
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b1, 5'd5);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0);
    chk("sb_ra_busy", {31'b0, u_if.ra_busy}, 32'h1);
    chk("sb_busy_any", {31'b0, u_if.busy_any}, 32'h1);
    drive(1'b1, 5'd5, 32'h5, 1'b0, 5'd5, 5'd0, 1'b1, 5'd5);
    chk("sb_byp_mask", {31'b0, u_if.ra_busy}, 32'h0);
    chk("sb_nobyp_nomask", {31'b0, a_if.ra_busy}, 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0);
    chk("sb_wr_claim_busy", {31'b0, u_if.ra_busy}, 32'h1);
    drive(1'b1, 5'd5, 32'h5, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0);
    chk("sb_any_unmasked", {31'b0, u_if.busy_any}, 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0);
    chk("sb_clear_ra_busy", {31'b0, u_if.ra_busy}, 32'h0);
    chk("sb_clear_busy_any", {31'b0, u_if.busy_any}, 32'h0);
    chk("sb_alt_clear", {31'b0, a_if.busy_any}, 32'h0);

    // Double claim, single write clears
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd6, 1'b1, 5'd6);
    tick();
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd6, 1'b0, 5'd0);
    chk("dbl_rb_busy", {31'b0, u_if.rb_busy}, 32'h1);
    drive(1'b1, 5'd6, 32'h6, 1'b0, 5'd6, 5'd6, 1'b0, 5'd0);
    tick();
    idle();
    chk("dbl_busy_any", {31'b0, u_if.busy_any}, 32'h0);

    // rd_en hold
    drive(1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2, 1'b0, 5'd0);
    tick();
    chk("hold_first", u_if.ra_data, 32'h55);
    drive(1'b1, 5'd2, 32'h66, 1'b0, 5'd2, 5'd2, 1'b0, 5'd0);
    tick();
    chk("hold_during_wr", u_if.ra_data, 32'h55);
    idle();
    tick();
    chk("hold_idle", u_if.ra_data, 32'h55);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2, 1'b0, 5'd0);
    tick();
    chk("hold_reread", u_if.ra_data, 32'h66);

    // Reset discards a same-cycle write and claim
    rst = 1'b1;
    drive(1'b1, 5'd10, 32'hAB, 1'b1, 5'd10, 5'd10, 1'b1, 5'd10);
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd2, 1'b0, 5'd0);
    chk("rst_mid_busy", {31'b0, u_if.ra_busy}, 32'h0);
    chk("rst_mid_rdata", u_if.ra_data, 32'h0);
    tick();
    chk("rst_mid_mem", u_if.ra_data, 32'h0);
    chk("rst_mid_r2", u_if.rb_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
